// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB arbiter and its round-robin picker.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_CDB_ENTRIES   = 2;
    localparam int unsigned RO_BUFFER_ENTRIES = 16;
    localparam int unsigned CDB_TAG_W         = $clog2(RO_BUFFER_ENTRIES);

    typedef logic [31:0] rv32i_word;

    // Result handed over by a functional unit.
    typedef struct packed {
        logic [CDB_TAG_W-1:0] tag;
        rv32i_word            value;
        rv32i_word            target_pc;
    } fu_result_t;

    // One CDB lane; tag 0 marks an idle lane.
    typedef struct packed {
        logic [CDB_TAG_W-1:0] tag;
        rv32i_word            value;
        rv32i_word            target_pc;
    } cdb_entry_t;

    typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;

    function automatic cdb_entry_t to_cdb_entry(input fu_result_t r);
        cdb_entry_t e;
        e.tag       = r.tag;
        e.value     = r.value;
        e.target_pc = r.target_pc;
        return e;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: grants up to NUM_LANES occupied units,
// scanning from rr_ptr, and maps the k-th grant onto lane k.
module cdb_rr_picker #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_LANES = 2,
    localparam int unsigned PTR_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                 occ,
    input  logic [PTR_W-1:0]                   rr_ptr,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [NUM_LANES-1:0][PTR_W-1:0]    lane_src,
    output logic [NUM_LANES-1:0]               lane_vld,
    output logic [PTR_W-1:0]                   rr_ptr_next
);

    // Scan units in rotated order; pointer follows the last granted unit.
    always_comb begin
        int cnt;
        int idx;
        grant       = '0;
        lane_src    = '0;
        lane_vld    = '0;
        rr_ptr_next = rr_ptr;
        cnt         = 0;
        idx         = 0;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            idx = (int'(rr_ptr) + off) % int'(NUM_REQ);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (i == idx && occ[i] && cnt < int'(NUM_LANES)) begin
                    grant[i] = 1'b1;
                    for (int k = 0; k < int'(NUM_LANES); k++) begin
                        if (k == cnt) begin
                            lane_src[k] = PTR_W'(i);
                            lane_vld[k] = 1'b1;
                        end
                    end
                    rr_ptr_next = PTR_W'((i + 1) % int'(NUM_REQ));
                    cnt++;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry holding buffer per functional unit, round-robin
// grant of up to NUM_LANES buffered results per cycle onto registered lanes.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_LANES = NUM_CDB_ENTRIES,
    parameter int unsigned TAG_W     = CDB_TAG_W,
    localparam int unsigned PTR_W    = $clog2(NUM_REQ),
    localparam int unsigned BUSY_W   = $clog2(NUM_LANES) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  fu_result_t [NUM_REQ-1:0]  req_result,
    output logic [NUM_REQ-1:0]        req_ready,
    output cdb_t                      cdb,
    output logic [BUSY_W-1:0]         lanes_busy
);

    logic [NUM_REQ-1:0]              occ_q, occ_d;
    fu_result_t [NUM_REQ-1:0]        res_buf_q, res_buf_d;
    logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
    cdb_t                            cdb_q, cdb_d;
    logic [BUSY_W-1:0]               lanes_busy_q, lanes_busy_d;

    logic [NUM_REQ-1:0]              grant;
    logic [NUM_LANES-1:0][PTR_W-1:0] lane_src;
    logic [NUM_LANES-1:0]            lane_vld;
    logic [NUM_REQ-1:0]              accept;

    cdb_rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .NUM_LANES (NUM_LANES)
    ) u_picker (
        .occ         (occ_q),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .lane_src    (lane_src),
        .lane_vld    (lane_vld),
        .rr_ptr_next (rr_ptr_d)
    );

    // A buffer draining this cycle can take a new result at the same edge.
    assign req_ready = ~occ_q | grant;

    // Tag 0 handshakes complete but are never buffered (ROB entry 0 reserved).
    always_comb begin
        accept = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            accept[i] = req_valid[i] & req_ready[i] & (req_result[i].tag != TAG_W'(0));
        end
    end

    // Next buffer state, lane data and busy count.
    always_comb begin
        occ_d        = occ_q;
        res_buf_d    = res_buf_q;
        cdb_d        = '0;
        lanes_busy_d = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (accept[i]) begin
                occ_d[i]     = 1'b1;
                res_buf_d[i] = req_result[i];
            end else if (grant[i]) begin
                occ_d[i] = 1'b0;
            end
        end
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            if (lane_vld[k]) begin
                cdb_d[k]     = to_cdb_entry(res_buf_q[lane_src[k]]);
                lanes_busy_d = lanes_busy_d + BUSY_W'(1);
            end
        end
    end

    // Control state; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q        <= '0;
            rr_ptr_q     <= '0;
            cdb_q        <= '0;
            lanes_busy_q <= '0;
        end else begin
            occ_q        <= occ_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_q        <= cdb_d;
            lanes_busy_q <= lanes_busy_d;
        end
    end

    // Payload storage; only meaningful while the matching occ bit is set.
    always_ff @(posedge clk) begin
        res_buf_q <= res_buf_d;
    end

    assign cdb        = cdb_q;
    assign lanes_busy = lanes_busy_q;

endmodule
